// File: rtl/i8080_bus_cycle_if.sv
// i8080 machine-cycle bus bundle: control request side plus external
// system bus pins, grouped so the sequencer sees one port.
interface i8080_bus_cycle_if #(
  parameter int XLEN = 8
);
  logic              req;
  logic [2:0]        kind;
  logic [2*XLEN-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   rdata;
  logic [2*XLEN-1:0] a;
  logic [XLEN-1:0]   d_out;
  logic              d_oe;
  logic [XLEN-1:0]   d_in;
  logic              sync;
  logic              dbin;
  logic              wr_n;
  logic              ready;

  modport master (
    output req, kind, addr, wdata, d_in, ready,
    input  busy, done, rdata, a, d_out, d_oe, sync, dbin, wr_n
  );

  modport slave (
    input  req, kind, addr, wdata, d_in, ready,
    output busy, done, rdata, a, d_out, d_oe, sync, dbin, wr_n
  );
endinterface

// File: rtl/i8080_bus_cycle.sv
// i8080 machine-cycle sequencer: T1/T2/TW/T3 with READY waits,
// status byte in T1, read capture and write strobing.
module i8080_bus_cycle #(
  parameter int XLEN = 8
) (
  input logic              clk,
  input logic              rst,
  i8080_bus_cycle_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        kind_q;
  logic [2*XLEN-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;

  logic       accept;
  logic       in_data;
  logic       is_rd;
  logic       is_io;
  logic [7:0] status;

  assign accept  = bus.req &&
                   (state == S_IDLE || state == S_T3);
  assign in_data = (state == S_T2 || state == S_TW);

  always_comb begin
    status = 8'h00;
    is_rd  = 1'b0;
    is_io  = 1'b0;
    unique case (kind_q)
      3'd0: begin status = 8'hA2; is_rd = 1'b1; end
      3'd1: begin status = 8'h82; is_rd = 1'b1; end
      3'd2: status = 8'h00;
      3'd3: begin status = 8'h86; is_rd = 1'b1; end
      3'd4: status = 8'h04;
      3'd5: begin
        status = 8'h42;
        is_rd  = 1'b1;
        is_io  = 1'b1;
      end
      3'd6: begin status = 8'h10; is_io = 1'b1; end
      3'd7: begin status = 8'h23; is_rd = 1'b1; end
      default: status = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2,
      S_TW:   state_nx = bus.ready ? S_T3 : S_TW;
      S_T3:   state_nx = accept ? S_T1 : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      kind_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        kind_q  <= bus.kind;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (in_data && bus.ready && is_rd)
        rdata_q <= bus.d_in;
    end
  end

  // Write data stays on the bus from T2 through the T3 strobe.
  logic wr_drive;
  assign wr_drive = !is_rd &&
                    (in_data || state == S_T3);

  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.done  = (state == S_T3);
    bus.sync  = (state == S_T1);
    bus.dbin  = is_rd && in_data;
    bus.wr_n  = !(!is_rd && state == S_T3);
    bus.d_oe  = (state == S_T1) || wr_drive;
    bus.d_out = '0;
    if (state == S_T1)
      bus.d_out = XLEN'(status);
    else if (wr_drive)
      bus.d_out = wdata_q;
    bus.rdata = rdata_q;
    bus.a     = is_io ? {addr_q[XLEN-1:0], addr_q[XLEN-1:0]}
                      : addr_q;
  end

endmodule
